// File: rtl/mic_i2s_rx.sv
// mic_i2s_rx: I2S master receiver for a stereo pair of MEMS microphones.
//
// Generates SCK and WS for both mics and deserializes the shared data line
// into a left and a right shift register. Each complete frame is latched
// into holding registers for the downstream DMA stage. The selected channel
// is presented sign-extended to 32 bits.
//
// Ports:
//   CLK, RESET     system clock, synchronous active-high reset
//   enable         run the interface; low returns the block to IDLE
//   mic_sck        I2S bit clock (period 2*CLK_DIV CLK cycles)
//   mic_ws         I2S word select, 0 = left (mic 0), 1 = right (mic 1)
//   mic_sd         shared serial data, already synchronized to CLK
//   select         2'b01 = right channel, anything else = left channel
//   mic_data       selected holding register, sign-extended
//   read_ready     an unacknowledged frame is held
//   read_ack       one-cycle pulse, consumer is done with the current frame
//   overrun_count  saturating count of frames overwritten before an ack
//   dbg_state      current FSM state (IDLE=0, WARMUP=1, RUN=2)
//
// Handshake: read_ready is a level. A read_ack seen while read_ready=1
// clears it on the next cycle; read_ack while read_ready=0 is ignored.
// A frame latch in the same cycle as read_ack wins: read_ready stays 1
// and the frame is not counted as an overrun.
//
// Configuration macro: MIC_OVERRUN_CNT_EN builds the overrun counter;
// without it overrun_count is tied to zero.

module mic_i2s_rx #(
    parameter int CLK_DIV        = 8,
    parameter int SAMPLE_BITS    = 24,
    parameter int STARTUP_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        enable,
    output logic        mic_sck,
    output logic        mic_ws,
    input  logic        mic_sd,
    input  logic [1:0]  select,
    output logic [31:0] mic_data,
    output logic        read_ready,
    input  logic        read_ack,
    output logic [15:0] overrun_count,
    output logic [1:0]  dbg_state
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int WW = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = (STARTUP_FRAMES > 0) ? WW'(STARTUP_FRAMES - 1) : '0;
    localparam logic [5:0]    FRAME_END = 6'(32 + SAMPLE_BITS);
    localparam logic [4:0]    OFS_LAST  = 5'(SAMPLE_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WW-1:0]          warm_cnt_q, warm_cnt_d;
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic                   sck_q, sck_d;
    logic                   ws_q, ws_d;
    logic [5:0]             slot_cnt_q, slot_cnt_d;
    logic [SAMPLE_BITS-1:0] shl_q, shl_d;
    logic [SAMPLE_BITS-1:0] shr_q, shr_d;
    logic                   frame_done_q, frame_done_d;
    logic [31:0]            hold_l_q, hold_l_d;
    logic [31:0]            hold_r_q, hold_r_d;
    logic                   ready_q, ready_d;

    logic       running;
    logic       div_wrap;
    logic       rise_evt;
    logic       fall_evt;
    logic       capture;
    logic       frame_evt;
    logic       latch;
    logic [5:0] slot_inc;

    function automatic logic [31:0] sext(input logic [SAMPLE_BITS-1:0] v);
        return {{(32 - SAMPLE_BITS){v[SAMPLE_BITS-1]}}, v};
    endfunction

    // Timing only advances while enabled and out of IDLE; dropping enable
    // zeroes everything on the next edge, discarding any partial frame.
    assign running   = enable && (state_q != ST_IDLE);
    assign div_wrap  = running && (div_cnt_q == DIV_LAST);
    assign rise_evt  = div_wrap && !sck_q;
    assign fall_evt  = div_wrap && sck_q;
    assign slot_inc  = slot_cnt_q + 6'd1;
    // Offset 0 of each slot is the I2S one-bit delay; data sits at 1..SAMPLE_BITS.
    assign capture   = rise_evt && (slot_cnt_q[4:0] != 5'd0) && (slot_cnt_q[4:0] <= OFS_LAST);
    assign frame_evt = rise_evt && (slot_cnt_q == FRAME_END);
    // frame_done_q is one cycle after the last bit was shifted in, so the
    // shift registers already hold the complete frame here.
    assign latch     = frame_done_q && (state_q == ST_RUN);

    // FSM next state
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        case (state_q)
            ST_IDLE: begin
                warm_cnt_d = '0;
                if (enable) begin
                    state_d = (STARTUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (frame_done_q) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!enable) begin
            state_d    = ST_IDLE;
            warm_cnt_d = '0;
        end
    end

    // SCK / WS generation and deserialization
    always_comb begin
        div_cnt_d    = '0;
        sck_d        = 1'b0;
        ws_d         = 1'b0;
        slot_cnt_d   = '0;
        shl_d        = '0;
        shr_d        = '0;
        frame_done_d = 1'b0;
        if (running) begin
            div_cnt_d    = div_wrap ? '0 : div_cnt_q + 1'b1;
            sck_d        = div_wrap ? !sck_q : sck_q;
            ws_d         = ws_q;
            slot_cnt_d   = slot_cnt_q;
            shl_d        = shl_q;
            shr_d        = shr_q;
            frame_done_d = frame_evt;
            if (fall_evt) begin
                // WS follows the new slot position, so it changes one SCK
                // ahead of the slot's MSB.
                slot_cnt_d = slot_inc;
                ws_d       = slot_inc[5];
            end
            if (capture) begin
                if (slot_cnt_q[5]) begin
                    shr_d = {shr_q[SAMPLE_BITS-2:0], mic_sd};
                end else begin
                    shl_d = {shl_q[SAMPLE_BITS-2:0], mic_sd};
                end
            end
        end
    end

    // Holding registers and consumer handshake
    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        ready_d  = ready_q;
        if (latch) begin
            hold_l_d = sext(shl_q);
            hold_r_d = sext(shr_q);
            ready_d  = 1'b1;
        end else if (read_ack && ready_q) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            warm_cnt_q   <= '0;
            div_cnt_q    <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            slot_cnt_q   <= '0;
            shl_q        <= '0;
            shr_q        <= '0;
            frame_done_q <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            div_cnt_q    <= div_cnt_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            slot_cnt_q   <= slot_cnt_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            frame_done_q <= frame_done_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            ready_q      <= ready_d;
        end
    end

`ifdef MIC_OVERRUN_CNT_EN
    logic [15:0] ovr_q, ovr_d;
    logic        overrun_hit;

    // An overrun is a latch over an unread frame that is not being acked now.
    assign overrun_hit = latch && ready_q && !read_ack;

    always_comb begin
        ovr_d = ovr_q;
        if (overrun_hit && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_count = ovr_q;
`else
    assign overrun_count = '0;
`endif

    assign mic_sck    = sck_q;
    assign mic_ws     = ws_q;
    assign read_ready = ready_q;
    assign mic_data   = (select == 2'b01) ? hold_r_q : hold_l_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mic_i2s_rx.sv
// Bench for mic_i2s_rx: two instances (no warm-up / two warm-up frames)
// share CLK, RESET, enable, select and a behavioural I2S mic model.

module tb_mic_i2s_rx;

  localparam int SB = 24;

`ifdef MIC_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        enable;
  logic        mic_sd;
  logic [1:0]  select;
  logic        read_ack;
  logic        read_ack2;

  logic        sck0, ws0, ready0;
  logic [31:0] data0;
  logic [15:0] ovr0;
  logic [1:0]  dbg0;
  logic        sck2, ws2, ready2;
  logic [31:0] data2;
  logic [15:0] ovr2;
  logic [1:0]  dbg2;

  mic_i2s_rx #(.CLK_DIV(4), .SAMPLE_BITS(SB), .STARTUP_FRAMES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .enable(enable),
    .mic_sck(sck0), .mic_ws(ws0), .mic_sd(mic_sd), .select(select),
    .mic_data(data0), .read_ready(ready0), .read_ack(read_ack),
    .overrun_count(ovr0), .dbg_state(dbg0)
  );

  mic_i2s_rx #(.CLK_DIV(4), .SAMPLE_BITS(SB), .STARTUP_FRAMES(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .enable(enable),
    .mic_sck(sck2), .mic_ws(ws2), .mic_sd(mic_sd), .select(select),
    .mic_data(data2), .read_ready(ready2), .read_ack(read_ack2),
    .overrun_count(ovr2), .dbg_state(dbg2)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // mic model / timing monitor state
  logic [23:0] l_tab [8];
  logic [23:0] r_tab [8];
  logic [23:0] cur_l, cur_r, word;
  int  mic_cnt      = 0;
  logic mic_last_ws = 1'b1;
  int  frame_idx    = -1;
  int  lsb_cyc      = 0;
  int  lsb_count    = 0;
  bit  ack_on_latch = 1'b0;
  bit  ack_clear    = 1'b0;
  logic sck_prev    = 1'b0;
  logic ws_prev     = 1'b0;
  bit  rise_valid   = 1'b0;
  int  last_rise    = 0;
  int  rises_since  = 0;
  int  sck_per_bad  = 0;
  int  ws_bad       = 0;
  int  ws_len_bad   = 0;
  int  ws_changes   = 0;
  int  ws_rise_prev = 0;
  int  ws_rise_last = 0;

  // Mic behaviour: detects a WS change on an SCK rise, then drives the
  // MSB after the following SCK fall; unused bit times are driven high.
  initial begin
    l_tab[0] = 24'h7FFFFF; r_tab[0] = 24'h800001;
    l_tab[1] = 24'h123456; r_tab[1] = 24'hABCDEF;
    l_tab[2] = 24'h800000; r_tab[2] = 24'h000001;
    l_tab[3] = 24'h0F0F0F; r_tab[3] = 24'hF0F0F0;
    l_tab[4] = 24'h5A5A5A; r_tab[4] = 24'h3C3C3C;
    l_tab[5] = 24'h111111; r_tab[5] = 24'hFEDCBA;
    l_tab[6] = 24'h654321; r_tab[6] = 24'hC00003;
    l_tab[7] = 24'h000000; r_tab[7] = 24'h000000;
    cur_l = '0;
    cur_r = '0;
    mic_sd = 1'b1;
    forever begin
      @(negedge CLK);
      if (ack_clear) begin
        read_ack  = 1'b0;
        ack_clear = 1'b0;
      end
      if (!enable || RESET) begin
        mic_last_ws = 1'b1;
        mic_cnt     = 0;
        rise_valid  = 1'b0;
        rises_since = 0;
      end else begin
        if (sck0 && !sck_prev) begin
          if (rise_valid && (cyc - last_rise != 8)) sck_per_bad++;
          last_rise   = cyc;
          rise_valid  = 1'b1;
          rises_since++;
          if (ws0 != mic_last_ws) begin
            mic_cnt = 0;
            if (!ws0 && frame_idx < 7) begin
              frame_idx++;
              cur_l = l_tab[frame_idx];
              cur_r = r_tab[frame_idx];
            end
          end else begin
            mic_cnt++;
          end
          mic_last_ws = ws0;
          if (ws0 && mic_cnt == SB) begin
            lsb_cyc = cyc;
            lsb_count++;
            if (ack_on_latch) begin
              read_ack     = 1'b1;
              ack_on_latch = 1'b0;
              ack_clear    = 1'b1;
            end
          end
        end
        if (!sck0 && sck_prev) begin
          word = mic_last_ws ? cur_r : cur_l;
          mic_sd = (mic_cnt < SB) ? word[SB-1-mic_cnt] : 1'b1;
        end
        if (ws0 != ws_prev) begin
          if (!(sck_prev && !sck0)) ws_bad++;
          if (rises_since != 32) ws_len_bad++;
          rises_since = 0;
          ws_changes++;
          if (ws0) begin
            ws_rise_prev = ws_rise_last;
            ws_rise_last = cyc;
          end
        end
      end
      sck_prev = sck0;
      ws_prev  = ws0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  logic rdy_before;

  task automatic wait_frame(input int n);
    int k;
    k = 0;
    while (lsb_count < n && k < 3000) begin
      rdy_before = ready0;
      tick();
      k++;
    end
    if (lsb_count < n) check("frame_timeout", 32'(lsb_count), 32'(n));
  endtask

  task automatic idle_window(input string tag, input int n);
    int hi;
    hi = 0;
    repeat (n) begin
      tick();
      if (sck0 || ws0) hi++;
    end
    check(tag, 32'(hi), 32'd0);
  endtask

  task automatic pulse_ack();
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
  endtask

  int r1, r2, k;
  logic ps;

  initial begin
    RESET     = 1'b1;
    enable    = 1'b0;
    select    = 2'b00;
    read_ack  = 1'b0;
    read_ack2 = 1'b0;
    repeat (4) tick();

    // reset state
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_ws", 32'(ws0), 32'd0);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_data_l", data0, 32'd0);
    check("rst_state", 32'(dbg0), 32'd0);
    check("rst_ovr", 32'(ovr0), 32'd0);
    check("rst2_sck_ws_rdy", {29'd0, sck2, ws2, ready2}, 32'd0);
    check("rst2_ovr", 32'(ovr2), 32'd0);
    select = 2'b01;
    tick();
    check("rst_data_r", data0, 32'd0);
    RESET = 1'b0;
    idle_window("idle_no_sck", 20);
    check("idle_state", 32'(dbg0), 32'd0);

    // enable: state entry and SCK period
    enable = 1'b1;
    tick();
    check("en_state0", 32'(dbg0), 32'd2);
    check("en_state2", 32'(dbg2), 32'd1);
    r1 = -1;
    r2 = -1;
    ps = sck0;
    k  = 0;
    while (r2 < 0 && k < 100) begin
      tick();
      if (sck0 && !ps) begin
        if (r1 < 0) r1 = cyc; else r2 = cyc;
      end
      ps = sck0;
      k++;
    end
    check("sck_period", 32'(r2 - r1), 32'd8);

    // frame 0: latency and sign extension
    wait_frame(1);
    check("f0_rdy_before", 32'(rdy_before), 32'd0);
    check("f0_ready", 32'(ready0), 32'd1);
    check("f0_latency", 32'(cyc - lsb_cyc), 32'd1);
    check("f0_warm_ready2", 32'(ready2), 32'd0);
    select = 2'b10; tick();
    check("f0_sel10", data0, 32'h007FFFFF);
    select = 2'b01; tick();
    check("f0_sel01", data0, 32'hFF800001);
    select = 2'b11; tick();
    check("f0_sel11", data0, 32'h007FFFFF);
    select = 2'b00; tick();
    check("f0_sel00", data0, 32'h007FFFFF);
    pulse_ack();
    check("ack_clears", 32'(ready0), 32'd0);
    pulse_ack();
    check("ack_idle_ignored", 32'(ready0), 32'd0);
    check("ack_no_ovr", 32'(ovr0), 32'd0);

    // frames 1..3 without acks
    wait_frame(2);
    check("f1_ready", 32'(ready0), 32'd1);
    check("f1_warm_ready2", 32'(ready2), 32'd0);
    check("f1_ovr", 32'(ovr0), 32'd0);
    select = 2'b00; tick();
    check("f1_left", data0, 32'h00123456);
    select = 2'b01; tick();
    check("f1_right", data0, 32'hFFABCDEF);

    wait_frame(3);
    check("f2_ready", 32'(ready0), 32'd1);
    check("f2_ready2", 32'(ready2), 32'd1);
    check("f2_ovr", 32'(ovr0), OVR_EN ? 32'd1 : 32'd0);
    check("frame_len", 32'(ws_rise_last - ws_rise_prev), 32'd512);
    select = 2'b00; tick();
    check("f2_left", data0, 32'hFF800000);
    check("f2_left2", data2, 32'hFF800000);
    select = 2'b01; tick();
    check("f2_right", data0, 32'h00000001);
    check("f2_right2", data2, 32'h00000001);

    wait_frame(4);
    check("f3_ready", 32'(ready0), 32'd1);
    check("f3_ovr", 32'(ovr0), OVR_EN ? 32'd2 : 32'd0);
    select = 2'b00; tick();
    check("f3_left", data0, 32'h000F0F0F);
    select = 2'b01; tick();
    check("f3_right", data0, 32'hFFF0F0F0);

    // frame 4: ack lands in the latch cycle
    ack_on_latch = 1'b1;
    wait_frame(5);
    check("f4_ready_kept", 32'(ready0), 32'd1);
    check("f4_ovr_same", 32'(ovr0), OVR_EN ? 32'd2 : 32'd0);
    select = 2'b00; tick();
    check("f4_left", data0, 32'h005A5A5A);
    select = 2'b01; tick();
    check("f4_right", data0, 32'h003C3C3C);

    // frame 5: drop enable mid right slot
    k = 0;
    while (!(frame_idx == 5 && mic_last_ws == 1'b1 && mic_cnt >= 10) && k < 3000) begin
      tick();
      k++;
    end
    check("drop_reached", 32'(k < 3000), 32'd1);
    enable = 1'b0;
    tick();
    check("drop_state", 32'(dbg0), 32'd0);
    check("drop_sck", 32'(sck0), 32'd0);
    check("drop_ws", 32'(ws0), 32'd0);
    check("drop_ready", 32'(ready0), 32'd1);
    check("drop_right", data0, 32'h003C3C3C);
    select = 2'b00; tick();
    check("drop_left", data0, 32'h005A5A5A);
    idle_window("drop_no_sck", 20);
    pulse_ack();
    check("idle_ack_clears", 32'(ready0), 32'd0);

    // re-enable: clean frame 6 from slot 0
    enable = 1'b1;
    wait_frame(6);
    check("f6_rdy_before", 32'(rdy_before), 32'd0);
    check("f6_ready", 32'(ready0), 32'd1);
    check("f6_latency", 32'(cyc - lsb_cyc), 32'd1);
    check("f6_ovr", 32'(ovr0), OVR_EN ? 32'd2 : 32'd0);
    select = 2'b10; tick();
    check("f6_left", data0, 32'h00654321);
    select = 2'b01; tick();
    check("f6_right", data0, 32'hFFC00003);

    // timing monitor totals
    check("sck_period_all", 32'(sck_per_bad), 32'd0);
    check("ws_on_sck_fall", 32'(ws_bad), 32'd0);
    check("ws_every_32_sck", 32'(ws_len_bad), 32'd0);
    check("ws_changes_seen", 32'(ws_changes >= 12), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mic_i2s_rx.md
Name: mic_i2s_rx

Overview:
- Dual-microphone I2S master receiver that sits directly upstream of the mic DMA stage.
- Generates the bit clock (SCK) and word select (WS) for a stereo pair of I2S MEMS mics, deserializes both channels, and latches each complete frame into holding registers.
- Presents the selected channel sign-extended to 32 bits with a level-valid flag. The DMA reads that flag, steers the channel select, and acknowledges each frame.

Parameters:
- CLK_DIV, 8, CLK cycles per SCK half-period; legal range >=2; SCK period = 2*CLK_DIV CLK cycles.
- SAMPLE_BITS, 24, valid MSB-first data bits per channel slot; legal range 16..31.
- STARTUP_FRAMES, 4, complete frames discarded after enable rises (mic wake-up); 0 means no discard.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  run the I2S interface; low returns the block to IDLE.
- mic_sck  out  1  I2S bit clock to both mics.
- mic_ws  out  1  I2S word select; 0 = left slot (mic 0), 1 = right slot (mic 1).
- mic_sd  in  1  shared I2S serial data, pre-synchronized externally.
- select  in  2  channel select from DMA; 2'b01 = right/mic 1, any other value = left/mic 0.
- mic_data  out  32  selected holding register, sign-extended.
- read_ready  out  1  level flag: an unacknowledged frame is held.
- read_ack  in  1  one-cycle pulse; consumer finished with the current frame.
- overrun_count  out  16  saturating count of overwritten frames (feature-dependent).

Behaviour:
- Reset values: mic_sck=0, mic_ws=0, read_ready=0, both holding registers=0 (so mic_data=0), overrun_count=0, state=IDLE, all counters=0.
- States and transitions:
  - IDLE: counters held at 0, SCK=0, WS=0. Moves to WARMUP when enable=1; goes straight to RUN if STARTUP_FRAMES=0.
  - WARMUP: full I2S timing runs but frames are not latched. Moves to RUN after STARTUP_FRAMES frame completions.
  - RUN: frames are latched.
  - enable=0 in any state: next cycle is IDLE, the partial frame is dropped. Holding registers and read_ready keep their values.
- SCK generation:
  - div_cnt counts 0..CLK_DIV-1; mic_sck toggles when div_cnt==CLK_DIV-1.
  - rise_evt / fall_evt are internal one-cycle strobes coincident with the toggle to 1 / to 0.
- Framing:
  - 64 SCK per frame. slot_cnt[5:0] increments on fall_evt and wraps 63->0.
  - mic_ws is registered from slot_cnt[5] on fall_evt.
  - Standard I2S one-bit delay: the channel MSB is sampled on rise_evt at slot offset 1.
- Capture:
  - On rise_evt with offset o=slot_cnt[4:0] in 1..SAMPLE_BITS, mic_sd shifts into the left or right shift register, selected by slot_cnt[5]. Other offsets are ignored.
- Frame completion:
  - Occurs on the rise_evt where slot_cnt==32+SAMPLE_BITS.
  - In RUN, on the next CLK both holding registers load the sign-extended shift registers; bit SAMPLE_BITS-1 is replicated into bits 31..SAMPLE_BITS.
  - read_ready=1 in that same cycle. Latency: last data bit sampled -> read_ready high = 1 CLK.
- read_ready and read_ack:
  - read_ack with read_ready=1 clears read_ready next cycle.
  - read_ack with read_ready=0 is ignored.
- Simultaneous latch and ack: the latch wins; read_ready stays 1 and no overrun is counted.
- Latch with read_ready=1 and no ack: the holding registers are overwritten, read_ready stays 1, and an overrun is counted.
- mic_data is combinational from select and the holding registers. The consumer may switch select freely between ack events; values are stable until the next latch.

Optional Feature:
- MIC_OVERRUN_CNT_EN:
  - Defined: overrun_count increments on each overrun and saturates at 16'hFFFF. It clears only on RESET.
  - Undefined: overrun_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset (CLK_DIV=4, SAMPLE_BITS=24, STARTUP_FRAMES=0) -> mic_sck, mic_ws, read_ready and mic_data all 0; no SCK edges while enable=0.
- SCK/WS timing: enable=1 -> mic_sck period 8 CLK; mic_ws toggles on SCK falling edges every 32 SCK; one frame = 512 CLK.
- Data path: drive left 24'h7FFFFF, right 24'h800001 on mic_sd -> read_ready rises 1 CLK after the right LSB is sampled:
  - select=2'b10 gives mic_data=32'h007FFFFF.
  - select=2'b01 gives mic_data=32'hFF800001.
- Warm-up: STARTUP_FRAMES=2 -> read_ready stays 0 through the first 2 frames and rises at the end of frame 3 with frame-3 data.
- Handshake/overrun: no read_ack for 3 frames -> read_ready held at 1, data equals the latest frame, overrun_count=2 with MIC_OVERRUN_CNT_EN defined (0 without). Pulse read_ack in the same cycle as a latch -> read_ready stays 1 and the count is unchanged.
- Mid-operation drop: deassert enable mid-right slot -> next cycle IDLE, mic_sck=0, read_ready and data unchanged. Re-enable -> a clean frame from slot 0.
